// File: rtl/reg_write_decoder.sv
// rtl/reg_write_decoder.sv - dual-port register-file write decoder with clear sweep
// Port A has priority on same-index collisions; collisions are counted and saturate.
module reg_write_decoder #(
   parameter int SEL_W          = 5,
   parameter int MASK_ZERO      = 1,
   parameter int SWEEP_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_a_i,
   input  logic [SEL_W-1:0]         sel_a_i,
   input  logic                     en_b_i,
   input  logic [SEL_W-1:0]         sel_b_i,
   input  logic                     start_sweep_i,
   output logic                     ready_o,
   output logic [(2**SEL_W)-1:0]    ld_o,
   output logic [(2**SEL_W)-1:0]    src_o,
   output logic                     sweep_o,
   output logic                     conflict_o,
   output logic [7:0]               conflict_cnt_o
);

   localparam int NUM_OUT = 2**SEL_W;

   typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

   state_t             state;
   logic [SEL_W-1:0]   idx;

   logic               a_ok;
   logic               b_ok;
   logic               coll;
   logic [NUM_OUT-1:0] vec_a;
   logic [NUM_OUT-1:0] vec_b;

   function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [NUM_OUT-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // Index 0 is the hard-wired zero register when masked: it never loads in RUN.
   always_comb begin
      a_ok  = en_a_i && !((MASK_ZERO != 0) && (sel_a_i == '0));
      b_ok  = en_b_i && !((MASK_ZERO != 0) && (sel_b_i == '0));
      coll  = a_ok && b_ok && (sel_a_i == sel_b_i);
      vec_a = a_ok ? onehot(sel_a_i) : '0;
      vec_b = b_ok ? onehot(sel_b_i) : '0;
   end

   assign ready_o = (state == RUN);
   assign sweep_o = (state == SWEEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= (SWEEP_ON_RESET != 0) ? SWEEP : RUN;
         idx            <= '0;
         ld_o           <= '0;
         src_o          <= '0;
         conflict_o     <= 1'b0;
         conflict_cnt_o <= 8'd0;
      end else begin
         case (state)
            SWEEP: begin
               ld_o       <= onehot(idx);
               src_o      <= '0;
               conflict_o <= 1'b0;
               if (&idx) begin
                  state <= RUN;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               ld_o       <= vec_a | vec_b;
               src_o      <= vec_b & ~vec_a;
               conflict_o <= coll;
               if (coll && (conflict_cnt_o != 8'hFF))
                  conflict_cnt_o <= conflict_cnt_o + 8'd1;
               if (start_sweep_i) begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_decoder.sv
// tb/tb_reg_write_decoder.sv - directed self-checking bench for reg_write_decoder
module tb_reg_write_decoder;

   logic        clk;
   logic        rst_n;
   logic        en_a_i;
   logic [4:0]  sel_a_i;
   logic        en_b_i;
   logic [4:0]  sel_b_i;
   logic        start_sweep_i;
   logic        ready_o;
   logic [31:0] ld_o;
   logic [31:0] src_o;
   logic        sweep_o;
   logic        conflict_o;
   logic [7:0]  conflict_cnt_o;

   int total;
   int bad;

   reg_write_decoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_a_i         (en_a_i),
      .sel_a_i        (sel_a_i),
      .en_b_i         (en_b_i),
      .sel_b_i        (sel_b_i),
      .start_sweep_i  (start_sweep_i),
      .ready_o        (ready_o),
      .ld_o           (ld_o),
      .src_o          (src_o),
      .sweep_o        (sweep_o),
      .conflict_o     (conflict_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_a_i = 1'b0; sel_a_i = '0;
      en_b_i = 1'b0; sel_b_i = '0;
      start_sweep_i = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      rst_n = 1'b0;
      #12;
      chk("rst_ld",    ld_o, 32'h0);
      chk("rst_src",   src_o, 32'h0);
      chk("rst_conf",  {31'b0, conflict_o}, 32'h0);
      chk("rst_cnt",   {24'b0, conflict_cnt_o}, 32'h0);
      chk("rst_sweep", {31'b0, sweep_o}, 32'h1);
      chk("rst_ready", {31'b0, ready_o}, 32'h0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 32; k++) begin
         logic [31:0] e;
         e = 32'h1 << k;
         step();
         chk($sformatf("sweep_ld%0d", k), ld_o, e);
         chk($sformatf("sweep_src%0d", k), src_o, 32'h0);
      end
      chk("end_sweep_o", {31'b0, sweep_o}, 32'h0);
      chk("end_ready_o", {31'b0, ready_o}, 32'h1);
      step();
      chk("edge33_ld", ld_o, 32'h0);

      en_a_i = 1'b1; sel_a_i = 5'd5; en_b_i = 1'b1; sel_b_i = 5'd9;
      step();
      chk("two_ld",   ld_o, 32'h0000_0220);
      chk("two_src",  src_o, 32'h0000_0200);
      chk("two_conf", {31'b0, conflict_o}, 32'h0);

      en_a_i = 1'b1; sel_a_i = 5'd0; en_b_i = 1'b1; sel_b_i = 5'd0;
      step();
      chk("zero_ld",   ld_o, 32'h0);
      chk("zero_conf", {31'b0, conflict_o}, 32'h0);
      chk("zero_cnt",  {24'b0, conflict_cnt_o}, 32'h0);

      en_a_i = 1'b0; sel_a_i = 5'd3; en_b_i = 1'b1; sel_b_i = 5'd3;
      step();
      chk("bonly_ld",  ld_o, 32'h0000_0008);
      chk("bonly_src", src_o, 32'h0000_0008);

      en_a_i = 1'b1; sel_a_i = 5'd31; en_b_i = 1'b0; sel_b_i = 5'd31;
      step();
      chk("aonly_ld",  ld_o, 32'h8000_0000);
      chk("aonly_src", src_o, 32'h0);

      idle();
      step();
      chk("idle_ld", ld_o, 32'h0);

      en_a_i = 1'b1; sel_a_i = 5'd7; en_b_i = 1'b1; sel_b_i = 5'd7;
      step();
      chk("coll_ld",   ld_o, 32'h0000_0080);
      chk("coll_src",  src_o, 32'h0);
      chk("coll_conf", {31'b0, conflict_o}, 32'h1);
      chk("coll_cnt",  {24'b0, conflict_cnt_o}, 32'h1);
      for (int k = 0; k < 299; k++) step();
      chk("sat_cnt", {24'b0, conflict_cnt_o}, 32'hFF);
      idle();
      step();
      chk("post_conf", {31'b0, conflict_o}, 32'h0);
      chk("post_cnt",  {24'b0, conflict_cnt_o}, 32'hFF);

      start_sweep_i = 1'b1; en_a_i = 1'b1; sel_a_i = 5'd4;
      step();
      chk("ss_ld",    ld_o, 32'h0000_0010);
      chk("ss_sweep", {31'b0, sweep_o}, 32'h1);
      chk("ss_ready", {31'b0, ready_o}, 32'h0);
      // Requests during a sweep must be ignored.
      idle();
      en_a_i = 1'b1; sel_a_i = 5'd20; en_b_i = 1'b1; sel_b_i = 5'd20;
      start_sweep_i = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         logic [31:0] e;
         e = 32'h1 << k;
         step();
         chk($sformatf("sw2_ld%0d", k), ld_o, e);
         chk($sformatf("sw2_conf%0d", k), {31'b0, conflict_o}, 32'h0);
      end
      chk("sw2_cnt_kept", {24'b0, conflict_cnt_o}, 32'hFF);
      idle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ld",    ld_o, 32'h0);
      chk("mid_rst_cnt",   {24'b0, conflict_cnt_o}, 32'h0);
      chk("mid_rst_sweep", {31'b0, sweep_o}, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      chk("restart_ld0", ld_o, 32'h1);
      step();
      chk("restart_ld1", ld_o, 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_write_decoder.md
REG_WRITE_DECODER -- requirements
Module: reg_write_decoder

Interface
REQ-001 Parameter SEL_W, default 5, selects the index width.
REQ-002 Derived constant NUM_OUT = 2**SEL_W (32 at default) SHALL NOT be overridable.
REQ-003 Parameter MASK_ZERO, default 1: when 1, index 0 SHALL never be loaded in RUN (hard-wired zero register).
REQ-004 Parameter SWEEP_ON_RESET, default 1: when 1, a clear sweep SHALL start after reset release.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en_a_i  in  1  write request, port A (priority port).
REQ-008 sel_a_i  in  SEL_W  destination index, port A.
REQ-009 en_b_i  in  1  write request, port B.
REQ-010 sel_b_i  in  SEL_W  destination index, port B.
REQ-011 start_sweep_i  in  1  single-cycle request for a clear sweep.
REQ-012 ready_o  out  1  high when requests are accepted (state RUN).
REQ-013 ld_o  out  NUM_OUT  registered load-enable vector, bit j loads register j.
REQ-014 src_o  out  NUM_OUT  registered data-select per register: 1 = port B data, 0 = port A/clear.
REQ-015 sweep_o  out  1  high while in state SWEEP.
REQ-016 conflict_o  out  1  registered one-cycle pulse on A/B same-index collision.
REQ-017 conflict_cnt_o  out  8  saturating collision count.

Function
REQ-018 States: SWEEP and RUN only; ready_o = (state==RUN), sweep_o = (state==SWEEP), both decoded from the state register.
REQ-019 All of ld_o, src_o, conflict_o SHALL be registered; latency from request to ld_o is exactly 1 cycle; each ld_o bit is a one-cycle pulse per accepted request.
REQ-020 RUN: ld_o next = onehot(sel_a_i) if en_a_i, OR onehot(sel_b_i) if en_b_i; disabled ports contribute nothing; both disabled gives all-zero.
REQ-021 RUN with MASK_ZERO=1: a request to index 0 SHALL contribute no bit and SHALL NOT count as a conflict.
REQ-022 RUN: src_o bit j next = 1 only when port B loads j and port A does not; all other bits 0.
REQ-023 Collision (en_a_i, en_b_i both 1, sel_a_i==sel_b_i, not masked): port A wins, only that bit set with src_o bit 0, conflict_o=1 next cycle, conflict_cnt_o increments, saturating at 255.
REQ-024 Different indices on A and B SHALL both load in the same cycle (two bits set).
REQ-025 SWEEP: internal SEL_W-bit counter idx; each cycle ld_o next = onehot(idx), src_o next = 0, idx increments; idx==NUM_OUT-1 issues its pulse and moves to RUN on the same edge, idx cleared to 0.
REQ-026 SWEEP covers all NUM_OUT indices including 0 regardless of MASK_ZERO; en_a_i/en_b_i/start_sweep_i ignored in SWEEP; conflict_o stays 0.
REQ-027 start_sweep_i=1 in RUN: requests that cycle are still processed normally; state becomes SWEEP with idx=0 on the next edge.
REQ-028 conflict_cnt_o SHALL NOT be cleared by a sweep; only reset clears it.

Reset
REQ-029 rst_n low SHALL immediately set ld_o=0, src_o=0, conflict_o=0, conflict_cnt_o=0, idx=0, state=SWEEP if SWEEP_ON_RESET else RUN.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; after release the sweep restarts from index 0.
REQ-031 First edge after release with SWEEP_ON_RESET=1 SHALL produce ld_o=onehot(0).

Verification
REQ-032 Reset release, defaults -> ld_o = 0x00000001, 0x00000002 ... 0x80000000 on edges 1..32, sweep_o falls and ready_o rises on edge 32, ld_o=0 on edge 33.
REQ-033 RUN, A=(1,5), B=(1,9) -> next cycle ld_o=0x00000220, src_o=0x00000200, conflict_o=0.
REQ-034 RUN, A=(1,7), B=(1,7) -> ld_o=0x00000080, src_o=0, conflict_o=1, conflict_cnt_o 0->1; 300 consecutive collisions -> conflict_cnt_o holds 255.
REQ-035 RUN, MASK_ZERO=1, A=(1,0), B=(1,0) -> ld_o=0, conflict_o=0; A=(0,3), B=(1,3) -> ld_o=0x00000008, src_o=0x00000008.
REQ-036 RUN, start_sweep_i=1 with A=(1,4) -> ld_o=0x00000010 next edge, then 32-cycle sweep; rst_n pulsed low at sweep index 10 -> outputs zero at once, sweep restarts at 0x00000001.
